// File: rtl/mixedInclude_package.sv
// Shared wordline constants for the mixed example.
// Holds the B buffer size defaults and the default-config occupancy type.
package mixedInclude_package;

    localparam int BSIZE      = 10;
    localparam int BSIZE_LOG2 = 4;

    typedef logic [BSIZE_LOG2-1:0] b_fifo_cnt_t;

endpackage

// File: rtl/b_mod_ptr.sv
// Modulo-DEPTH incrementing pointer with enable and synchronous clear.
// Ports: clk, rst_n (async low), clr (sync, wins), en (advance), ptr (value).
module b_mod_ptr #(
    parameter int DEPTH = 10,
    localparam int W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_nxt;

    // Wrap explicitly so non-power-of-two depths work.
    always_comb begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == W'(DEPTH - 1))
            ptr_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (clr)
            ptr <= '0;
        else if (en)
            ptr <= ptr_nxt;
    end

endmodule

// File: rtl/b_wordline_fifo.sv
// Ready/valid FIFO of DEPTH wordlines, WIDTH bits each, flop storage.
// Ports: clk, rst_n, flush, in_valid/in_ready/in_data, out_valid/out_ready/
// out_data, count (occupancy), almost_full, drop_cnt (saturating drops).
module b_wordline_fifo
    import mixedInclude_package::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = BSIZE,
    parameter int AFULL_THRESH = DEPTH - 2,
    parameter bit DROP_ON_FULL = 1'b0,
    localparam int CNT_W       = $clog2(DEPTH + 1),
    localparam int PTR_W       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output logic             almost_full,
    output logic [7:0]       drop_cnt
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;

    assign full        = (count == CNT_W'(DEPTH));
    assign out_valid   = (count != '0);
    assign almost_full = (count >= CNT_W'(AFULL_THRESH));
    assign out_data    = mem[rd_ptr];

    // Full blocks writes even when a pop happens in the same cycle.
    assign in_ready = DROP_ON_FULL ? 1'b1 : !full;
    assign push     = in_valid & in_ready & !full & !flush;
    assign pop      = out_valid & out_ready & !flush;
    assign drop     = DROP_ON_FULL & in_valid & full & !flush;

    b_mod_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (push),
        .ptr   (wr_ptr)
    );

    b_mod_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (pop),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (flush)
            count <= '0;
        else if (push && !pop)
            count <= count + 1'b1;
        else if (pop && !push)
            count <= count - 1'b1;
    end

    // Flush leaves the drop history intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end

endmodule

// File: tb/tb_b_wordline_fifo.sv
// Directed bench for b_wordline_fifo in backpressure and drop modes.
// Two instances share clock and reset; each has its own handshake signals.
module tb_b_wordline_fifo;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        fl, iv, ordy;
    logic [31:0] id;
    logic        ir, ov, af;
    logic [31:0] od;
    logic [3:0]  cnt;
    logic [7:0]  dc;

    logic        dfl, dv, dordy;
    logic [31:0] dd;
    logic        dir, dov, daf;
    logic [31:0] dod;
    logic [3:0]  dcnt;
    logic [7:0]  ddc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    b_wordline_fifo #(.DROP_ON_FULL(1'b0)) dut_bp (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (fl),
        .in_valid    (iv),
        .in_ready    (ir),
        .in_data     (id),
        .out_valid   (ov),
        .out_ready   (ordy),
        .out_data    (od),
        .count       (cnt),
        .almost_full (af),
        .drop_cnt    (dc)
    );

    b_wordline_fifo #(.DROP_ON_FULL(1'b1)) dut_dr (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (dfl),
        .in_valid    (dv),
        .in_ready    (dir),
        .in_data     (dd),
        .out_valid   (dov),
        .out_ready   (dordy),
        .out_data    (dod),
        .count       (dcnt),
        .almost_full (daf),
        .drop_cnt    (ddc)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        fl = 0; iv = 0; ordy = 0; id = '0;
        dfl = 0; dv = 0; dordy = 0; dd = '0;
        #1;
        chk("rst_count", 32'(cnt), 0);
        chk("rst_out_valid", 32'(ov), 0);
        chk("rst_out_data", od, 0);
        chk("rst_in_ready", 32'(ir), 1);
        chk("rst_afull", 32'(af), 0);
        chk("rst_drop_cnt", 32'(dc), 0);
        chk("rst_dr_in_ready", 32'(dir), 1);
        #11;
        rst_n = 1'b1;

        // fill backpressure FIFO
        for (int i = 0; i < 10; i++) begin
            iv = 1; id = 32'(i);
            step();
        end
        iv = 0;
        chk("fill_count", 32'(cnt), 10);
        chk("fill_in_ready", 32'(ir), 0);
        chk("fill_afull", 32'(af), 1);
        chk("fill_head", od, 0);

        // drain in order
        ordy = 1;
        for (int i = 0; i < 10; i++) begin
            chk("drain_data", od, 32'(i));
            step();
        end
        ordy = 0;
        chk("drain_count", 32'(cnt), 0);
        chk("drain_out_valid", 32'(ov), 0);

        // refill then full with simultaneous pop
        for (int i = 0; i < 10; i++) begin
            iv = 1; id = 32'h10 + 32'(i);
            step();
        end
        iv = 1; id = 32'hAA; ordy = 1;
        step();
        iv = 0;
        chk("fullpop_count", 32'(cnt), 9);
        chk("fullpop_in_ready", 32'(ir), 1);
        chk("fullpop_head", od, 32'h11);

        // pop down to 6, then flush with traffic offered
        repeat (3) step();
        chk("preflush_count", 32'(cnt), 6);
        chk("preflush_head", od, 32'h14);
        fl = 1; iv = 1; id = 32'hBB; ordy = 1;
        step();
        fl = 0; iv = 0; ordy = 0;
        chk("flush_count", 32'(cnt), 0);
        chk("flush_out_valid", 32'(ov), 0);
        chk("flush_drop_cnt", 32'(dc), 0);
        chk("flush_afull", 32'(af), 0);

        // wrap-around streaming at count 3
        for (int k = 0; k < 3; k++) begin
            iv = 1; id = 32'h100 + 32'(k);
            step();
        end
        ordy = 1;
        for (int k = 0; k < 25; k++) begin
            id = 32'h103 + 32'(k);
            chk("wrap_data", od, 32'h100 + 32'(k));
            chk("wrap_count", 32'(cnt), 3);
            step();
        end
        iv = 0; ordy = 0;
        chk("wrap_end_count", 32'(cnt), 3);
        chk("wrap_end_head", od, 32'h119);

        // async reset at count 4, between edges
        iv = 1; id = 32'h200;
        step();
        iv = 0;
        chk("prerst_count", 32'(cnt), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(ov), 0);
        chk("arst_count", 32'(cnt), 0);
        chk("arst_afull", 32'(af), 0);
        chk("arst_out_data", od, 0);
        #3;
        rst_n = 1'b1;
        iv = 1; id = 32'h77;
        step();
        iv = 0;
        chk("post_rst_valid", 32'(ov), 1);
        chk("post_rst_data", od, 32'h77);
        chk("post_rst_count", 32'(cnt), 1);

        // drop mode: fill, drop, pop+drop, refill, saturate
        for (int i = 0; i < 10; i++) begin
            dv = 1; dd = 32'(i);
            step();
        end
        chk("dr_fill_count", 32'(dcnt), 10);
        chk("dr_in_ready", 32'(dir), 1);
        chk("dr_afull", 32'(daf), 1);
        dd = 32'hDEAD;
        repeat (5) step();
        chk("dr_drop5", 32'(ddc), 5);
        chk("dr_drop5_count", 32'(dcnt), 10);
        dordy = 1;
        step();
        dordy = 0;
        chk("dr_popdrop_cnt", 32'(ddc), 6);
        chk("dr_popdrop_count", 32'(dcnt), 9);
        chk("dr_popdrop_head", dod, 1);
        dd = 32'hA;
        step();
        chk("dr_refill_count", 32'(dcnt), 10);
        dd = 32'hDEAD;
        repeat (300) step();
        dv = 0;
        chk("dr_sat", 32'(ddc), 255);
        chk("dr_sat_count", 32'(dcnt), 10);
        chk("dr_sat_afull", 32'(daf), 1);
        dordy = 1;
        for (int i = 0; i < 10; i++) begin
            chk("dr_drain_data", dod, 32'(i + 1));
            step();
        end
        dordy = 0;
        chk("dr_drain_count", 32'(dcnt), 0);
        chk("dr_drain_valid", 32'(dov), 0);
        chk("bp_drop_cnt_idle", 32'(dc), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
